// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, register offsets and CTRL bit layout for timer_dev. Rev 1.0
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_W        = 4;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

`default_nettype wire

// File: rtl/timer_core.sv
// timer_core: countdown FSM holding COUNT and the interrupt flag. Rev 1.0
`default_nettype none

module timer_core
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [31:0] preset,
  input  logic        ctrl_wr,
  output logic [31:0] count,
  output logic        irq_flag,
  output logic        en_clr
);

  timer_state_e state_q, state_d;
  logic [31:0]  count_q, count_d;
  logic         irq_flag_q, irq_flag_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    en_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Saturate at zero so PRESET of 0 or 1 expires without wrapping.
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (mode == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
        end else begin
          en_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ctrl_wr) irq_flag_d = 1'b0;
  end

  assign count    = count_q;
  assign irq_flag = irq_flag_q;

endmodule

`default_nettype wire

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer (CTRL/PRESET/COUNT) with maskable IRQ. Rev 1.0
// TIMER_AUTORELOAD_EN defined: MODE=01 auto-reloads; otherwise MODE is forced to 00.
`default_nettype none

module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_wdata;
  logic [31:0]       preset_q, preset_d;
  logic [1:0]        reg_sel;
  logic              ctrl_wr, preset_wr;
  logic [31:0]       core_count;
  logic              core_irq_flag, core_en_clr;
  logic              unused_addr_bits;

  // The DM stage resolves the window, so only the word offset matters here.
  assign reg_sel          = Addr[3:2];
  assign unused_addr_bits = ^{Addr[31:4], Addr[1:0], BASE_ADDR};
  assign ctrl_wr          = WE && (reg_sel == REG_CTRL);
  assign preset_wr        = WE && (reg_sel == REG_PRESET);

`ifdef TIMER_AUTORELOAD_EN
  assign ctrl_wdata = Din[CTRL_W-1:0];
`else
  assign ctrl_wdata = {Din[CTRL_IM], MODE_ONESHOT, Din[CTRL_EN]};
`endif

  always_comb begin
    ctrl_d = ctrl_q;
    if (core_en_clr) ctrl_d[CTRL_EN] = 1'b0;
    // A CPU write in the same cycle as the one-shot EN clear takes priority.
    if (ctrl_wr) ctrl_d = ctrl_wdata;
  end

  always_comb begin
    preset_d = preset_q;
    if (preset_wr) preset_d = Din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
    end
  end

  timer_core u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl_q[CTRL_EN]),
    .mode     (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]),
    .preset   (preset_q),
    .ctrl_wr  (ctrl_wr),
    .count    (core_count),
    .irq_flag (core_irq_flag),
    .en_clr   (core_en_clr)
  );

  always_comb begin
    Dout = '0;
    case (reg_sel)
      REG_CTRL:   Dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
      REG_PRESET: Dout = preset_q;
      REG_COUNT:  Dout = core_count;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = ctrl_q[CTRL_IM] & core_irq_flag;

endmodule

`default_nettype wire

// File: tb/tb_timer_dev.sv
// tb_timer_dev: randomized and directed checks of timer_dev against a timeline reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_timer_dev;

  localparam logic [31:0] BASE = 32'h0000_7f00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] Addr = BASE;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;

  timer_dev #(.BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a run is described by the edge at which COUNT loads
  // and the edge at which it expires; COUNT is derived arithmetically.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_p;
  logic        m_flag, m_active;
  longint      m_t, m_t_load, m_t_int;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ctrl_mask(input logic [31:0] d);
`ifdef TIMER_AUTORELOAD_EN
    return d[3:0];
`else
    return {d[3], 2'b00, d[0]};
`endif
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_preset = '0; m_count = '0; m_p = '0;
    m_flag = 1'b0; m_active = 1'b0;
    m_t = 0; m_t_load = 0; m_t_int = 0;
  endtask

  task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] d);
    logic   en_old, reload, clr_en;
    longint k;
    en_old = m_ctrl[0];
    reload = (m_ctrl[2:1] == 2'b01);
    clr_en = 1'b0;
    if (!m_active) begin
      if (en_old) begin
        m_active = 1'b1;
        m_t_load = m_t + 1;
      end
    end else if (m_t == m_t_load) begin
      m_p     = m_preset;
      m_count = m_preset;
      m_t_int = m_t + ((m_preset > 32'd1) ? longint'(m_preset) : 64'sd1);
    end else if (m_t <= m_t_int) begin
      if (!en_old) begin
        m_active = 1'b0;
      end else begin
        k = m_t - m_t_load;
        m_count = (longint'(m_p) <= k) ? 32'd0 : m_p - 32'(k);
        if (m_t == m_t_int) m_flag = 1'b1;
      end
    end else begin
      m_active = 1'b0;
      if (reload) m_flag = 1'b0;
      else        clr_en = 1'b1;
    end
    if (clr_en) m_ctrl[0] = 1'b0;
    if (we && a == 2'd0) begin
      m_ctrl = ctrl_mask(d);
      m_flag = 1'b0;
    end
    if (we && a == 2'd1) m_preset = d;
    m_t++;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] a;
      a = 2'(i);
      Addr = BASE | {28'b0, a, 2'b00};
      #1;
      check_eq($sformatf("rd%0d", i), Dout, model_read(a));
    end
    check_eq("irq", {31'b0, IRQ}, {31'b0, m_ctrl[3] & m_flag});
  endtask

  task automatic cycle(input logic we, input logic [1:0] a, input logic [31:0] d);
    WE = we; Addr = BASE | {28'b0, a, 2'b00}; Din = d;
    @(posedge clk);
    if (reset) model_step(we, a, d);
    #1;
    WE = 1'b0; Din = '0;
    check_all();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = BASE | {28'b0, a, 2'b00};
    #1;
    v = Dout;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int r;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    idle(2);

    // One-shot: PRESET=5, CTRL=EN|IM
    cycle(1'b1, 2'd1, 32'd5);
    cycle(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 2'd0, 32'd0);
      if (k >= 2 && k <= 7) begin
        rd(2'd2, v);
        check_eq("os_count", v, 32'(7 - k));
      end
      check_eq("os_irq", {31'b0, IRQ}, (k >= 7) ? 32'd1 : 32'd0);
    end
    rd(2'd0, v);
    check_eq("os_ctrl", v, 32'h8);
    cycle(1'b1, 2'd0, 32'h8);
    check_eq("os_irq_clr", {31'b0, IRQ}, 32'd0);
    idle(3);

    // Auto-reload request: PRESET=3, CTRL=EN|MODE01|IM
    cycle(1'b1, 2'd1, 32'd3);
    cycle(1'b1, 2'd0, 32'hB);
    rd(2'd0, v);
`ifdef TIMER_AUTORELOAD_EN
    check_eq("ar_ctrl", v, 32'hB);
`else
    check_eq("ar_ctrl", v, 32'h9);
`endif
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 2'd0, 32'd0);
`ifdef TIMER_AUTORELOAD_EN
      check_eq("ar_irq", {31'b0, IRQ}, (k >= 5 && (k - 5) % 6 == 0) ? 32'd1 : 32'd0);
`else
      check_eq("ar_irq", {31'b0, IRQ}, (k >= 5) ? 32'd1 : 32'd0);
`endif
    end
    cycle(1'b1, 2'd0, 32'h0);
    idle(3);

    // Mid-count stop at COUNT=7, then restart
    cycle(1'b1, 2'd1, 32'd10);
    cycle(1'b1, 2'd0, 32'h1);
    idle(5);
    rd(2'd2, v);
    check_eq("stop_pre", v, 32'd7);
    cycle(1'b1, 2'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 2'd0, 32'd0);
      rd(2'd2, v);
      check_eq("stop_hold", v, 32'd6);
      check_eq("stop_irq", {31'b0, IRQ}, 32'd0);
    end
    cycle(1'b1, 2'd0, 32'h1);
    idle(2);
    rd(2'd2, v);
    check_eq("restart", v, 32'd10);
    cycle(1'b1, 2'd0, 32'h0);
    idle(3);

    // PRESET=0 expires after one CNT cycle and never wraps
    cycle(1'b1, 2'd1, 32'd0);
    cycle(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 2'd0, 32'd0);
      if (k >= 2) begin
        rd(2'd2, v);
        check_eq("p0_count", v, 32'd0);
      end
      check_eq("p0_irq", {31'b0, IRQ}, (k >= 3) ? 32'd1 : 32'd0);
    end
    cycle(1'b1, 2'd0, 32'h8);
    idle(3);

    // PRESET rewritten mid-run only affects the next load
    cycle(1'b1, 2'd1, 32'd4);
    cycle(1'b1, 2'd0, 32'hB);
    idle(2);
    cycle(1'b1, 2'd1, 32'd10);
    idle(3);
    rd(2'd2, v);
    check_eq("pw_end", v, 32'd0);
    check_eq("pw_irq", {31'b0, IRQ}, 32'd1);
`ifdef TIMER_AUTORELOAD_EN
    idle(3);
    rd(2'd2, v);
    check_eq("pw_reload", v, 32'd10);
`endif
    rd(2'd3, v);
    check_eq("reserved", v, 32'd0);
    cycle(1'b1, 2'd0, 32'h0);
    idle(3);

    // Asynchronous reset mid-count at COUNT=0x20
    cycle(1'b1, 2'd1, 32'h22);
    cycle(1'b1, 2'd0, 32'h9);
    idle(4);
    rd(2'd2, v);
    check_eq("rst_pre", v, 32'h20);
    reset = 1'b0;
    model_reset();
    rd(2'd2, v);
    check_eq("rst_count", v, 32'd0);
    rd(2'd1, v);
    check_eq("rst_preset", v, 32'd0);
    check_eq("rst_irq", {31'b0, IRQ}, 32'd0);
    idle(3);
    reset = 1'b1;
    idle(3);
    rd(2'd0, v);
    check_eq("rst_ctrl", v, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       cycle(1'b1, 2'd0, $urandom | ((r < 5) ? 32'd1 : 32'd0));
      else if (r < 16) cycle(1'b1, 2'd1, 32'($urandom_range(0, 12)));
      else if (r < 18) cycle(1'b1, 2'd3, $urandom);
      else             cycle(1'b0, 2'd0, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_dev.md
# timer_dev

Memory-mapped programmable countdown timer on the data bus behind the DM stage. The DM stage decodes the timer windows (0x7f00–0x7f0b and 0x7f10–0x7f1b), forwards word stores here, and muxes this block's `Dout` into `lw` results. One instance per window. `IRQ` feeds the CP0 external-interrupt input.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_7f00: word-aligned base of this instance's 3-word window.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low (0 = reset).
- `Addr`  in  32: byte address from DM. Only `Addr[3:2]` is decoded; DM guarantees the address lies in this window.
- `WE`  in  1: word write strobe. DM already suppresses writes to COUNT and misaligned accesses.
- `Din`  in  32: write data.
- `Dout`  out  32: combinational read data for `Addr[3:2]`.
- `IRQ`  out  1: interrupt request.

## Operation
Registers, selected by `Addr[3:2]`:
- 0 CTRL: [0] EN, [2:1] MODE, [3] IM. Bits [31:4] are not stored and read 0.
- 1 PRESET: 32-bit reload value.
- 2 COUNT: read-only current count.
- 3: reserved; reads 0, writes ignored.

FSM states: IDLE, LOAD, CNT, INT.
- IDLE: if EN=1, go to LOAD.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT:
  - if EN=0, go to IDLE; COUNT holds.
  - else if COUNT > 1, COUNT <= COUNT-1.
  - else COUNT <= 0, irq_flag <= 1, go to INT.
  - PRESET=0 or 1 therefore reaches INT after one CNT cycle.
- INT:
  - MODE=00 (one-shot): EN <= 0; go to IDLE. irq_flag stays 1 until the next CTRL write.
  - MODE=01 (auto-reload): go to IDLE, which reloads because EN is still 1. irq_flag clears on leaving INT (one-cycle pulse).
  - MODE=1x: treated as 00.

Output and register rules:
- `IRQ = IM & irq_flag`.
- A CTRL write clears irq_flag.
- A CPU write to CTRL in the same cycle as the FSM's EN clear in INT: the CPU write wins.
- A PRESET write during CNT affects only the next LOAD.
- A CTRL write with EN=0 during CNT stops the count in the following cycle.
- Arithmetic is unsigned 32-bit. COUNT never wraps below 0.

## Timing
- Reset (asynchronous, immediate): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, `IRQ`=0. `Dout` follows Addr (0 for any register after reset).
- Writes take effect at the `clk` edge where `WE`=1. Reads are same-cycle combinational and return the pre-edge value.
- From the edge that sets EN: IDLE→LOAD at the next edge, COUNT=PRESET one edge later, then one decrement per cycle.
- With PRESET=N≥1, `IRQ` rises N+2 edges after the EN write.
- Auto-reload period is N+3 cycles: LOAD + N CNT cycles + INT + IDLE.
- Reset deasserted mid-count: the block restarts in IDLE with all registers 0.

## Configuration
- `TIMER_AUTORELOAD_EN` defined: MODE=01 behaves as auto-reload, and MODE reads back as written.
- Not defined: MODE is forced to 00 on write and reads 00. Only one-shot behaviour exists.

## Structure
- Package `timer_pkg`: state encoding, register offsets (CTRL=0, PRESET=1, COUNT=2), CTRL bit indices (EN, MODE, IM).
- Sub-module `timer_core`: FSM, COUNT, irq_flag.
- Top `timer_dev`: address decode, CTRL/PRESET storage, read mux, write-priority logic.

## Test plan
- Reset low mid-count with COUNT=0x20 → all reads 0 and `IRQ`=0 immediately; after release, state is IDLE.
- PRESET=5, CTRL=0x9 (EN, one-shot, IM):
  - COUNT reads 5,4,3,2,1,0 on successive cycles.
  - `IRQ`=1 seven edges after the CTRL write and holds; CTRL reads 0x8.
  - Writing CTRL=0x8 drops `IRQ`.
- PRESET=3, CTRL=0xB (auto-reload, with `TIMER_AUTORELOAD_EN`) → one-cycle `IRQ` pulses every 6 cycles. Without the macro, a single latched `IRQ` and CTRL reads 0x9.
- Mid-count write CTRL=0x0 at COUNT=7 → COUNT freezes at 6 or 7 (one-edge latency) and no `IRQ`. Rewriting EN restarts from PRESET.
- PRESET=0 with EN → `IRQ` after LOAD plus one CNT cycle; COUNT stays 0 and never wraps to 0xFFFFFFFF.
- PRESET rewritten to 10 while counting from 4 → the current run ends at 0; the next auto-reload loads 10. Read of offset 3 returns 0.
